pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 16-bit Thumb-subset core. It sits beside the instruction decoder and register file. It generates per-stage enable, flush and bubble signals for the IF/ID/EX/MEM/WB pipeline. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits, and it traps on a data-memory timeout.

---
 rtl/pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// ----------------
// Pipeline sequencing controller for the 16-bit Thumb-subset core
// (IF/ID/EX/MEM/WB). It produces the per-stage enable, flush and bubble
// controls, resolves load-use hazards, taken-branch flushes and multi-cycle
// data-memory waits, and traps on a data-memory timeout.
//
// Ports
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_id_rn, i_id_rm       source register indices of the ID instruction
//   i_id_use_rn/_rm        ID instruction actually reads Rn / Rm
//   i_ex_memread           EX instruction is a load
//   i_ex_regwrite, i_ex_rd EX instruction writes register i_ex_rd
//   i_ex_br_taken          branch resolved taken in EX
//   i_mem_req, i_dmem_ack  MEM-stage access request / completion
//   o_pc_en, o_pc_sel_br   PC enable / PC loads branch target
//   o_ifid_en, o_ifid_flush   IF/ID enable / load NOP
//   o_idex_en, o_idex_bubble  ID/EX enable / load bubble
//   o_exmem_en             EX/MEM enable
//   o_memwb_en, o_memwb_bubble MEM/WB enable / load bubble
//   o_mem_err              sticky data-memory timeout flag
//   o_state                debug state: 00 RUN, 01 MEMWAIT, 11 TRAP
//   o_stall_cnt, o_flush_cnt  performance counters
//
// Optional feature: define PIPE_HAZARD_PERF_EN to build the saturating
// stall/flush counters; otherwise both counter ports are tied to zero.
//
// Handshake: i_mem_req is a level request for the MEM-stage access; the
// access completes on the first cycle in which i_dmem_ack is high. A request
// acknowledged in its own cycle never stalls.
module pipe_hazard_ctrl #(
    parameter int REG_W       = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [REG_W-1:0] i_id_rn,
    input  logic [REG_W-1:0] i_id_rm,
    input  logic             i_id_use_rn,
    input  logic             i_id_use_rm,
    input  logic             i_ex_memread,
    input  logic             i_ex_regwrite,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_br_taken,
    input  logic             i_mem_req,
    input  logic             i_dmem_ack,
    output logic             o_pc_en,
    output logic             o_pc_sel_br,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_en,
    output logic             o_idex_bubble,
    output logic             o_exmem_en,
    output logic             o_memwb_en,
    output logic             o_memwb_bubble,
    output logic             o_mem_err,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MEMWAIT = 2'b01,
        ST_TRAP    = 2'b11
    } state_t;

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic       r_mem_err;

    logic w_mem_stall;
    logic w_load_use;
    logic w_freeze;
    logic w_active;
    logic w_hold_fetch;

    assign w_mem_stall = i_mem_req & ~i_dmem_ack;
    assign w_load_use  = i_ex_memread & i_ex_regwrite &
                         ((i_id_use_rn & (i_id_rn == i_ex_rd)) |
                          (i_id_use_rm & (i_id_rm == i_ex_rd)));

    // Whole pipe frozen: trapped, a new un-acked access in RUN, or still
    // waiting. In MEMWAIT only the ack matters; the ack cycle itself is
    // evaluated like RUN so a branch or load-use held in EX/ID is applied
    // exactly once, on release.
    always_comb begin
        w_freeze = 1'b1;
        case (r_state)
            ST_RUN:     w_freeze = w_mem_stall;
            ST_MEMWAIT: w_freeze = ~i_dmem_ack;
            default:    w_freeze = 1'b1;
        endcase
    end

    assign w_active     = i_rst_n & ~w_freeze;
    // A taken branch overrides load-use: the dependent instruction is squashed.
    assign w_hold_fetch = w_load_use & ~i_ex_br_taken;

    assign o_pc_en        = w_active & ~w_hold_fetch;
    assign o_pc_sel_br    = w_active & i_ex_br_taken;
    assign o_ifid_en      = w_active & ~w_hold_fetch;
    assign o_ifid_flush   = w_active & i_ex_br_taken;
    assign o_idex_en      = w_active;
    assign o_idex_bubble  = w_active & (i_ex_br_taken | w_load_use);
    assign o_exmem_en     = w_active;
    assign o_memwb_en     = w_active;
    assign o_memwb_bubble = i_rst_n & w_freeze;

    assign o_mem_err = r_mem_err;
    assign o_state   = r_state;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= ST_MEMWAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                ST_MEMWAIT: begin
                    // An ack on the timeout cycle wins over the trap.
                    if (i_dmem_ack) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= 8'd0;
                    end else if (r_wait_cnt == 8'(MEM_TIMEOUT)) begin
                        r_state    <= ST_TRAP;
                        r_wait_cnt <= 8'd0;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_TRAP: begin
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= 8'd0;
                end
            endcase
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_count_stall;

    assign w_count_stall = ~o_pc_en & ((r_state == ST_RUN) | (r_state == ST_MEMWAIT));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_count_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (o_ifid_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  localparam int REG_W       = 4;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 16;

  // Output vector order: {pc_en, pc_sel_br, ifid_en, ifid_flush, idex_en,
  //                       idex_bubble, exmem_en, memwb_en, memwb_bubble}
  localparam logic [8:0] O_NORM  = 9'b101010110;
  localparam logic [8:0] O_BR    = 9'b111111110;
  localparam logic [8:0] O_LU    = 9'b000011110;
  localparam logic [8:0] O_STALL = 9'b000000001;
  localparam logic [8:0] O_RST   = 9'b000000000;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic [REG_W-1:0] id_rn = '0, id_rm = '0, ex_rd = '0;
  logic             id_use_rn = 0, id_use_rm = 0, ex_memread = 0, ex_regwrite = 0;
  logic             ex_br_taken = 0, mem_req = 0, dmem_ack = 0;

  logic             o_pc_en, o_pc_sel_br, o_ifid_en, o_ifid_flush, o_idex_en;
  logic             o_idex_bubble, o_exmem_en, o_memwb_en, o_memwb_bubble, o_mem_err;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;
  logic [8:0]       dut_o;

  assign dut_o = {o_pc_en, o_pc_sel_br, o_ifid_en, o_ifid_flush, o_idex_en,
                  o_idex_bubble, o_exmem_en, o_memwb_en, o_memwb_bubble};

  pipe_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_id_rn(id_rn), .i_id_rm(id_rm), .i_id_use_rn(id_use_rn), .i_id_use_rm(id_use_rm),
    .i_ex_memread(ex_memread), .i_ex_regwrite(ex_regwrite), .i_ex_rd(ex_rd),
    .i_ex_br_taken(ex_br_taken), .i_mem_req(mem_req), .i_dmem_ack(dmem_ack),
    .o_pc_en(o_pc_en), .o_pc_sel_br(o_pc_sel_br), .o_ifid_en(o_ifid_en),
    .o_ifid_flush(o_ifid_flush), .o_idex_en(o_idex_en), .o_idex_bubble(o_idex_bubble),
    .o_exmem_en(o_exmem_en), .o_memwb_en(o_memwb_en), .o_memwb_bubble(o_memwb_bubble),
    .o_mem_err(o_mem_err), .o_state(o_state),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks: trapped?, waiting on memory?, how many cycles waited so far,
  // the sticky error and the two event counts.
  bit m_trap = 0, m_waiting = 0, m_err = 0;
  int m_waited = 0;
  int m_stall = 0, m_flush = 0;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  function automatic logic [8:0] model_out();
    bit lu;
    lu = ex_memread && ex_regwrite &&
         ((id_use_rn && id_rn == ex_rd) || (id_use_rm && id_rm == ex_rd));
    if (!rst_n)                                return O_RST;
    if (m_trap)                                return O_STALL;
    if (m_waiting && !dmem_ack)                return O_STALL;
    if (!m_waiting && mem_req && !dmem_ack)    return O_STALL;
    if (ex_br_taken)                           return O_BR;
    if (lu)                                    return O_LU;
    return O_NORM;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_trap)    return 2'b11;
    if (m_waiting) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_edge(input logic [8:0] eo);
    if (!rst_n) begin
      m_trap = 0; m_waiting = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!m_trap && !eo[8] && m_stall < CNT_MAX) m_stall++;
      if (eo[5] && m_flush < CNT_MAX) m_flush++;
      if (m_trap) begin
        // stays until reset
      end else if (m_waiting) begin
        if (dmem_ack) begin
          m_waiting = 0; m_waited = 0;
        end else if (m_waited == MEM_TIMEOUT) begin
          m_waiting = 0; m_trap = 1; m_err = 1;
        end else begin
          m_waited++;
        end
      end else if (mem_req && !dmem_ack) begin
        m_waiting = 1; m_waited = 1;
      end
    end
  endtask

  // Last pre-edge samples, for hand-written constant checks.
  logic [8:0]       last_o;
  logic [1:0]       last_state;
  logic             last_err;
  logic [CNT_W-1:0] last_stall, last_flush;

  // One clock: sample at negedge, compare with the model, take the edge.
  task automatic step(input string nm);
    logic [8:0] eo;
    @(negedge clk);
    eo         = model_out();
    last_o     = dut_o;
    last_state = o_state;
    last_err   = o_mem_err;
    last_stall = o_stall_cnt;
    last_flush = o_flush_cnt;
    chk({nm, "/outs"},  32'(dut_o),     32'(eo));
    chk({nm, "/state"}, 32'(o_state),   32'(model_state()));
    chk({nm, "/err"},   32'(o_mem_err), 32'(m_err));
`ifdef PIPE_HAZARD_PERF_EN
    chk({nm, "/stall_cnt"}, 32'(o_stall_cnt), 32'(m_stall));
    chk({nm, "/flush_cnt"}, 32'(o_flush_cnt), 32'(m_flush));
`else
    chk({nm, "/stall_cnt"}, 32'(o_stall_cnt), 32'd0);
    chk({nm, "/flush_cnt"}, 32'(o_flush_cnt), 32'd0);
`endif
    @(posedge clk);
    model_edge(eo);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    id_rn = '0; id_rm = '0; ex_rd = '0;
    id_use_rn = 0; id_use_rm = 0; ex_memread = 0; ex_regwrite = 0;
    ex_br_taken = 0; mem_req = 0; dmem_ack = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step("reset");
    rst_n = 1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] rn, rm, rd;
    logic       use_rn, use_rm, memread, regwrite, br, req, ack;
    logic [8:0] exp;
  } vec_t;

  vec_t vt[12];

  initial begin
    //          rn  rm  rd  urn urm mrd rw  br  req ack exp
    vt[0]  = '{4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, O_NORM};
    vt[1]  = '{4'd3, 4'd0, 4'd3, 1, 0, 1, 1, 0, 0, 0, O_LU};   // Rn hit
    vt[2]  = '{4'd1, 4'd5, 4'd5, 0, 1, 1, 1, 0, 0, 0, O_LU};   // Rm hit
    vt[3]  = '{4'd0, 4'd7, 4'd0, 1, 0, 1, 1, 0, 0, 0, O_LU};   // r0 is real
    vt[4]  = '{4'd3, 4'd3, 4'd3, 0, 0, 1, 1, 0, 0, 0, O_NORM}; // not read
    vt[5]  = '{4'd3, 4'd0, 4'd3, 1, 0, 1, 0, 0, 0, 0, O_NORM}; // no regwrite
    vt[6]  = '{4'd3, 4'd0, 4'd3, 1, 0, 0, 1, 0, 0, 0, O_NORM}; // not a load
    vt[7]  = '{4'd2, 4'd4, 4'd3, 1, 1, 1, 1, 0, 0, 0, O_NORM}; // no match
    vt[8]  = '{4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0, 0, O_BR};
    vt[9]  = '{4'd3, 4'd0, 4'd3, 1, 0, 1, 1, 1, 0, 0, O_BR};   // br beats LU
    vt[10] = '{4'd0, 4'd0, 4'd9, 0, 0, 0, 0, 0, 1, 1, O_NORM}; // 1-cycle access
    vt[11] = '{4'd6, 4'd6, 4'd6, 1, 1, 1, 1, 0, 1, 1, O_LU};

    // ---------------- reset state ----------------
    idle();
    rst_n = 0;
    #1;
    step("rst_hold");
    chk("rst_outs_zero", 32'(last_o), 32'(O_RST));
    rst_n = 1;
    step("post_rst");
    chk("post_rst_state", 32'(last_state), 32'd0);
    chk("post_rst_outs", 32'(last_o), 32'(O_NORM));

    // ---------------- table vectors ----------------
    for (int i = 0; i < 12; i++) begin
      id_rn = vt[i].rn; id_rm = vt[i].rm; ex_rd = vt[i].rd;
      id_use_rn = vt[i].use_rn; id_use_rm = vt[i].use_rm;
      ex_memread = vt[i].memread; ex_regwrite = vt[i].regwrite;
      ex_br_taken = vt[i].br; mem_req = vt[i].req; dmem_ack = vt[i].ack;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_table", i), 32'(last_o), 32'(vt[i].exp));
    end

    // ---------------- load-use, then cleared ----------------
    idle();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 4'd3; id_rn = 4'd3; id_use_rn = 1;
    step("lu1");
    chk("lu_bubble", 32'(last_o), 32'(O_LU));
    idle();
    step("lu2");
    chk("lu_released", 32'(last_o), 32'(O_NORM));

    // ---------------- memory wait, 3 cycles ----------------
    do_reset();
    idle(); mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      step("mw");
      chk($sformatf("mw_frozen%0d", i), 32'(last_o), 32'(O_STALL));
    end
    chk("mw_state_waiting", 32'(last_state), 32'd1);
    dmem_ack = 1;
    step("mw_ack");
    chk("mw_release_outs", 32'(last_o), 32'(O_NORM));
    idle();
    step("mw_after");
    chk("mw_back_to_run", 32'(last_state), 32'd0);

    // ---------------- branch held through a 2-cycle wait ----------------
    do_reset();
    begin
      int flushes = 0;
      idle(); ex_br_taken = 1; mem_req = 1;
      for (int i = 0; i < 2; i++) begin
        step("bw");
        flushes += int'(last_o[5]);
      end
      dmem_ack = 1;
      step("bw_ack");
      flushes += int'(last_o[5]);
      chk("bw_ack_outs", 32'(last_o), 32'(O_BR));
      idle();
      step("bw_after");
      flushes += int'(last_o[5]);
      chk("bw_flush_once", 32'(flushes), 32'd1);
`ifdef PIPE_HAZARD_PERF_EN
      chk("bw_flush_cnt", 32'(last_flush), 32'd1);
      chk("bw_stall_cnt", 32'(last_stall), 32'd2);
`endif
    end

    // ---------------- ack on the timeout cycle ----------------
    do_reset();
    idle(); mem_req = 1;
    for (int i = 0; i < MEM_TIMEOUT; i++) step("ato");
    dmem_ack = 1;
    step("ato_ack");
    chk("ato_ack_state", 32'(last_state), 32'd1);
    chk("ato_ack_outs", 32'(last_o), 32'(O_NORM));
    idle();
    step("ato_after");
    chk("ato_run", 32'(last_state), 32'd0);
    chk("ato_no_err", 32'(last_err), 32'd0);

    // ---------------- timeout trap, held until reset ----------------
    do_reset();
    idle(); mem_req = 1;
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) step("to");
    idle(); dmem_ack = 1; ex_br_taken = 1;
    step("to_trap");
    chk("to_state_trap", 32'(last_state), 32'd3);
    chk("to_err", 32'(last_err), 32'd1);
    chk("to_frozen", 32'(last_o), 32'(O_STALL));
    idle();
    for (int i = 0; i < 3; i++) step("to_hold");
    chk("to_still_trap", 32'(last_state), 32'd3);
    do_reset();
    step("to_cleared");
    chk("to_clr_state", 32'(last_state), 32'd0);
    chk("to_clr_err", 32'(last_err), 32'd0);

    // ---------------- reset in the middle of a wait ----------------
    idle(); mem_req = 1;
    for (int i = 0; i < 5; i++) step("rmw");
    do_reset();
    step("rmw_after");
    chk("rmw_state", 32'(last_state), 32'd0);

    // ---------------- randomized against the model ----------------
    for (int seg = 0; seg < 2; seg++) begin
      for (int n = 0; n < 2000; n++) begin
        rst_n       = ($urandom_range(0, 59) != 0);
        id_rn       = 4'($urandom_range(0, 3));
        id_rm       = 4'($urandom_range(0, 3));
        ex_rd       = 4'($urandom_range(0, 3));
        id_use_rn   = 1'($urandom_range(0, 1));
        id_use_rm   = 1'($urandom_range(0, 1));
        ex_memread  = 1'($urandom_range(0, 1));
        ex_regwrite = 1'($urandom_range(0, 1));
        ex_br_taken = ($urandom_range(0, 7) == 0);
        mem_req     = ($urandom_range(0, 3) == 0);
        dmem_ack    = (seg == 0) ? ($urandom_range(0, 1) == 1)
                                 : ($urandom_range(0, 9) == 0);
        step($sformatf("rnd%0d_%0d", seg, n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
